// File: rtl/cpu_io_port_bridge_if.sv
// cpu_io_port_bridge_if: host handshake and CPU port signals of the CPU I/O bridge
interface cpu_io_port_bridge_if;
    logic [15:0] i_host_data;
    logic        i_host_valid;
    logic        o_host_ready;
    logic [15:0] o_host_rx_data;
    logic        o_host_rx_valid;
    logic        i_host_rx_ready;
    logic [15:0] i_output_port;
    logic [15:0] o_input_port;
    logic        o_interrupt;
    logic        o_overflow;
    logic        o_underflow;

    modport slave (
        input  i_host_data, i_host_valid, i_host_rx_ready, i_output_port,
        output o_host_ready, o_host_rx_data, o_host_rx_valid, o_input_port,
        o_interrupt, o_overflow, o_underflow
    );

    modport master (
        output i_host_data, i_host_valid, i_host_rx_ready, i_output_port,
        input  o_host_ready, o_host_rx_data, o_host_rx_valid, o_input_port,
        o_interrupt, o_overflow, o_underflow
    );
endinterface

// File: rtl/cpu_io_port_bridge.sv
// cpu_io_port_bridge: host<->CPU word bridge with input/output FIFOs, change-detected commands and interrupt pulses
module cpu_io_port_bridge #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int INT_PULSE = 2,
    parameter int HOLDOFF   = 4
) (
    input logic i_clk,
    input logic i_reset,
    cpu_io_port_bridge_if.slave bus
);
    localparam int IAW  = $clog2(IN_DEPTH);
    localparam int OAW  = $clog2(OUT_DEPTH);
    localparam int CMAX = INT_PULSE > HOLDOFF ? INT_PULSE : HOLDOFF;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RAISE, S_WAIT_ACK, S_HOLDOFF} state_t;

    logic [15:0]  in_mem [IN_DEPTH];
    logic [IAW-1:0] in_wp, in_rp;
    logic [IAW:0] in_cnt;
    logic [12:0]  out_mem [OUT_DEPTH];
    logic [OAW-1:0] out_wp, out_rp;
    logic [OAW:0] out_cnt;
    logic [15:0]  r_prev;
    state_t       state;
    logic [CW-1:0] cnt;
    logic         irq, ovf, unf;

    logic       cmd, in_full, in_empty, out_full, out_empty;
    logic       in_push, in_pop, pop_cmd, clr_cmd, data_cmd, out_push, out_pop;
    logic [1:0] op;

    assign op        = bus.i_output_port[15:14];
    assign cmd       = bus.i_output_port != r_prev;
    assign in_full   = in_cnt == IN_DEPTH[IAW:0];
    assign in_empty  = in_cnt == '0;
    assign out_full  = out_cnt == OUT_DEPTH[OAW:0];
    assign out_empty = out_cnt == '0;
    assign pop_cmd   = cmd && op[1];
    assign clr_cmd   = cmd && op == 2'b11;
    assign data_cmd  = cmd && op == 2'b01;
    assign in_push   = bus.i_host_valid && !in_full;
    assign in_pop    = pop_cmd && !in_empty;
    assign out_push  = data_cmd && !out_full;
    assign out_pop   = !out_empty && bus.i_host_rx_ready;

    assign bus.o_host_ready    = !in_full;
    assign bus.o_input_port    = in_empty ? 16'h0000 : in_mem[in_rp];
    assign bus.o_host_rx_valid = !out_empty;
    assign bus.o_host_rx_data  = {3'b000, out_mem[out_rp]};
    assign bus.o_interrupt     = irq;
    assign bus.o_overflow      = ovf;
    assign bus.o_underflow     = unf;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            in_wp   <= '0;
            in_rp   <= '0;
            in_cnt  <= '0;
            out_wp  <= '0;
            out_rp  <= '0;
            out_cnt <= '0;
            r_prev  <= 16'h0000;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            if (in_push) begin
                in_mem[in_wp] <= bus.i_host_data;
                in_wp         <= in_wp + IAW'(1);
            end
            if (in_pop)
                in_rp <= in_rp + IAW'(1);
            in_cnt <= in_cnt + (IAW+1)'(in_push) - (IAW+1)'(in_pop);
            if (out_push) begin
                out_mem[out_wp] <= bus.i_output_port[12:0];
                out_wp          <= out_wp + OAW'(1);
            end
            if (out_pop)
                out_rp <= out_rp + OAW'(1);
            out_cnt <= out_cnt + (OAW+1)'(out_push) - (OAW+1)'(out_pop);
            if (cmd)
                r_prev <= bus.i_output_port;
            // clear wins over a set raised by the same command
            ovf <= clr_cmd ? 1'b0 : ovf | (data_cmd && out_full);
            unf <= clr_cmd ? 1'b0 : unf | (pop_cmd && in_empty);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            irq   <= 1'b0;
        end else begin
            case (state)
                S_IDLE:
                    if (!in_empty) begin
                        state <= S_RAISE;
                        cnt   <= CW'(INT_PULSE - 1);
                        irq   <= 1'b1;
                    end
                S_RAISE:
                    if (cnt == '0) begin
                        state <= S_WAIT_ACK;
                        irq   <= 1'b0;
                    end else
                        cnt <= cnt - CW'(1);
                S_WAIT_ACK:
                    if (pop_cmd) begin
                        state <= HOLDOFF == 0 ? S_IDLE : S_HOLDOFF;
                        cnt   <= CW'(HOLDOFF == 0 ? 0 : HOLDOFF - 1);
                    end
                S_HOLDOFF:
                    if (cnt == '0)
                        state <= S_IDLE;
                    else
                        cnt <= cnt - CW'(1);
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
